tl_ctrl_multi: RTL

//  Parametrised traffic-light controller; successor to the fixed two-way NS/EW controller.

---
 rtl/tl_ctrl_multi_pkg.sv | 19 +
 rtl/tl_ctrl_multi_rr_pick.sv | 30 +++
 rtl/tl_ctrl_multi.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tl_ctrl_multi_pkg.sv
// rtl/tl_ctrl_multi_pkg.sv - shared state encoding and approach-index helper
package tl_ctrl_multi_pkg;

   localparam int PHASE_W = 2;

   typedef enum logic [2:0] {
      ST_ALL_RED = 3'd0,
      ST_GREEN   = 3'd1,
      ST_YELLOW  = 3'd2,
      ST_WALK    = 3'd3,
      ST_FLASH   = 3'd4
   } state_t;

   function automatic logic [PHASE_W-1:0] wrap_inc(input logic [PHASE_W-1:0] idx,
                                                   input int num_dir);
      return (int'(idx) >= num_dir - 1) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/tl_ctrl_multi_rr_pick.sv
// rtl/tl_ctrl_multi_rr_pick.sv - round-robin next-approach search
module tl_ctrl_multi_rr_pick
   import tl_ctrl_multi_pkg::*;
#(
   parameter int NUM_DIR = 2
)(
   input  logic [PHASE_W-1:0] i_phase,
   input  logic [NUM_DIR-1:0] i_sensor,
   input  logic               i_actuated,
   output logic [PHASE_W-1:0] o_next
);

   logic [PHASE_W-1:0] w_idx;
   logic               w_found;

   // Scan phase+1, phase+2, ... with wrap; falls back to plain rotation when nothing waits.
   always_comb begin
      o_next  = wrap_inc(i_phase, NUM_DIR);
      w_idx   = i_phase;
      w_found = 1'b0;
      for (int k = 0; k < NUM_DIR; k++) begin
         w_idx = wrap_inc(w_idx, NUM_DIR);
         if (i_actuated && !w_found && (|(i_sensor & (NUM_DIR'(1) << w_idx)))) begin
            o_next  = w_idx;
            w_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tl_ctrl_multi.sv
// rtl/tl_ctrl_multi.sv - multi-approach traffic-light controller with walk, clearance and flash
module tl_ctrl_multi
   import tl_ctrl_multi_pkg::*;
#(
   parameter int NUM_DIR    = 2,
   parameter int GREEN_CYC  = 20,
   parameter int MIN_GREEN  = 6,
   parameter int YELLOW_CYC = 4,
   parameter int ALLRED_CYC = 2,
   parameter int WALK_CYC   = 8,
   parameter int FLASH_HALF = 5,
   parameter int CNT_W      = 8
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               actuated,
   input  logic [NUM_DIR-1:0] sensor,
   input  logic               ped_req,
   input  logic               flash_en,
   output logic [NUM_DIR-1:0] red,
   output logic [NUM_DIR-1:0] yellow,
   output logic [NUM_DIR-1:0] green,
   output logic               walk,
   output logic [PHASE_W-1:0] phase
);

   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYC - 1);
   localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF - 1);

   state_t             r_state, w_state_n;
   logic [CNT_W-1:0]   r_timer, w_timer_n;
   logic [PHASE_W-1:0] r_phase, w_phase_n, w_pick;
   logic               r_ped_pend, w_ped_n;
   logic               r_flash_lit, w_lit_n;
   logic [NUM_DIR-1:0] r_red, r_yellow, r_green;
   logic               r_walk;
   logic [NUM_DIR-1:0] w_red_n, w_yel_n, w_grn_n, w_cur_oh, w_nxt_oh;
   logic               w_walk_n, w_enter, w_early_exit;

   tl_ctrl_multi_rr_pick #(.NUM_DIR(NUM_DIR)) u_pick (
      .i_phase    (r_phase),
      .i_sensor   (sensor),
      .i_actuated (actuated),
      .o_next     (w_pick)
   );

   assign w_cur_oh     = NUM_DIR'(1) << r_phase;
   assign w_early_exit = actuated && (r_timer >= MIN_LAST)
                         && !(|(sensor & w_cur_oh)) && (|(sensor & ~w_cur_oh));

   always_comb begin
      w_state_n = r_state;
      w_phase_n = r_phase;
      case (r_state)
         ST_ALL_RED: if (r_timer == ALLRED_LAST) begin
            if (flash_en)        w_state_n = ST_FLASH;
            else if (r_ped_pend) w_state_n = ST_WALK;
            else begin
               w_state_n = ST_GREEN;
               w_phase_n = w_pick;
            end
         end
         ST_GREEN:  if (r_timer == GREEN_LAST || w_early_exit) w_state_n = ST_YELLOW;
         ST_YELLOW: if (r_timer == YELLOW_LAST) w_state_n = ST_ALL_RED;
         ST_WALK:   if (r_timer == WALK_LAST) begin
            w_state_n = ST_GREEN;
            w_phase_n = w_pick;
         end
         ST_FLASH:  if (!flash_en) w_state_n = ST_ALL_RED;
         default:   w_state_n = ST_ALL_RED;
      endcase

      w_enter   = (w_state_n != r_state);
      w_timer_n = w_enter ? '0 : r_timer + 1'b1;
      w_lit_n   = r_flash_lit;
      // The flash timer wraps every half-period instead of running on.
      if (w_state_n == ST_FLASH) begin
         if (w_enter) begin
            w_lit_n = 1'b1;
         end else if (r_timer == FLASH_LAST) begin
            w_lit_n   = ~r_flash_lit;
            w_timer_n = '0;
         end
      end
      // A request arriving on the walk-entry cycle is served by that walk.
      w_ped_n = (w_enter && w_state_n == ST_WALK) ? 1'b0 : (r_ped_pend | ped_req);
   end

   always_comb begin
      w_red_n  = '1;
      w_yel_n  = '0;
      w_grn_n  = '0;
      w_walk_n = 1'b0;
      w_nxt_oh = NUM_DIR'(1) << w_phase_n;
      case (w_state_n)
         ST_GREEN: begin
            w_grn_n = w_nxt_oh;
            w_red_n = ~w_nxt_oh;
         end
         ST_YELLOW: begin
            w_yel_n = w_nxt_oh;
            w_red_n = ~w_nxt_oh;
         end
         ST_WALK:  w_walk_n = 1'b1;
         ST_FLASH: begin
            w_yel_n = w_lit_n ? NUM_DIR'(1) : '0;
            w_red_n = w_lit_n ? ~NUM_DIR'(1) : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_ALL_RED;
         r_timer     <= '0;
         r_phase     <= PHASE_W'(NUM_DIR - 1);
         r_ped_pend  <= 1'b0;
         r_flash_lit <= 1'b0;
         r_red       <= '1;
         r_yellow    <= '0;
         r_green     <= '0;
         r_walk      <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_timer     <= w_timer_n;
         r_phase     <= w_phase_n;
         r_ped_pend  <= w_ped_n;
         r_flash_lit <= w_lit_n;
         r_red       <= w_red_n;
         r_yellow    <= w_yel_n;
         r_green     <= w_grn_n;
         r_walk      <= w_walk_n;
      end
   end

   assign red    = r_red;
   assign yellow = r_yellow;
   assign green  = r_green;
   assign walk   = r_walk;
   assign phase  = r_phase;

endmodule
